// File: rtl/xpb_pkg.sv
// Shared definitions for the loadable XPB reduction table: FSM encoding and
// default geometry.
package xpb_pkg;
  localparam int XPB_IDX_BITS  = 5;
  localparam int XPB_DATA_BITS = 1024;
  localparam int XPB_LOAD_WORD = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } xpb_state_t;
endpackage

// File: rtl/xpb_entry_accum.sv
// Assembles LOAD_WORD-wide load beats into one DATA_BITS entry, LS word first.
// entry_o is the assembled entry including the word accepted this cycle.
module xpb_entry_accum #(
  parameter int DATA_BITS = 1024,
  parameter int LOAD_WORD = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 accept_i,
  input  logic [LOAD_WORD-1:0] word_i,
  output logic [DATA_BITS-1:0] entry_o,
  output logic                 entry_done_o
);
  localparam int WPE   = DATA_BITS / LOAD_WORD;
  localparam int CNT_W = (WPE > 1) ? $clog2(WPE) : 1;
  localparam logic [CNT_W-1:0] WLAST = CNT_W'(WPE - 1);

  logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic [DATA_BITS-1:0] acc_q, acc_d, ins;

  always_comb begin
    ins = acc_q;
    for (int w = 0; w < WPE; w++)
      if (word_cnt_q == CNT_W'(w)) ins[w*LOAD_WORD +: LOAD_WORD] = word_i;
    acc_d        = acc_q;
    word_cnt_d   = word_cnt_q;
    entry_done_o = accept_i && (word_cnt_q == WLAST);
    if (clear_i) begin
      word_cnt_d = '0;
    end else if (accept_i) begin
      acc_d      = ins;
      word_cnt_d = (word_cnt_q == WLAST) ? '0 : word_cnt_q + CNT_W'(1);
    end
  end

  assign entry_o = ins;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) word_cnt_q <= '0;
    else     word_cnt_q <= word_cnt_d;
  end

  // Every slot is overwritten before an entry completes, so no reset needed.
  always_ff @(posedge clk) acc_q <= acc_d;
endmodule

// File: rtl/xpb_lut_loadable.sv
// Run-time loadable XPB reduction table with NUM_PORTS independent registered
// lookup channels; entry 0 reads as zero.
module xpb_lut_loadable
  import xpb_pkg::*;
#(
  parameter int IDX_BITS  = XPB_IDX_BITS,
  parameter int DATA_BITS = XPB_DATA_BITS,
  parameter int LOAD_WORD = XPB_LOAD_WORD,
  parameter int NUM_PORTS = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load_start,
  input  logic                           load_valid,
  input  logic [LOAD_WORD-1:0]           load_word,
  input  logic                           load_last,
  output logic                           load_ready,
  output logic                           load_err,
  output logic                           table_ready,
  input  logic [NUM_PORTS-1:0]           rd_valid,
  input  logic [NUM_PORTS*IDX_BITS-1:0]  rd_idx,
  output logic [NUM_PORTS*DATA_BITS-1:0] rd_data,
  output logic [NUM_PORTS-1:0]           rd_data_valid,
  output logic [NUM_PORTS-1:0]           rd_err
);
  localparam int ENTRIES = 2 ** IDX_BITS;
  localparam logic [IDX_BITS-1:0] LAST_ENT = IDX_BITS'(ENTRIES - 2);

  xpb_state_t           state_q, state_d;
  logic [IDX_BITS-1:0]  entry_cnt_q, entry_cnt_d;
  logic                 load_err_q, load_err_d;
  logic                 accept, entry_done, wr_en, is_final, is_ready;
  logic [DATA_BITS-1:0] entry;
  logic [DATA_BITS-1:0] tbl_q [ENTRIES];

  assign accept   = (state_q == ST_LOAD) && load_valid && !load_start;
  assign is_final = entry_done && (entry_cnt_q == LAST_ENT);
  assign wr_en    = accept && entry_done;
  assign is_ready = (state_q == ST_READY);

  xpb_entry_accum #(
    .DATA_BITS (DATA_BITS),
    .LOAD_WORD (LOAD_WORD)
  ) u_accum (
    .clk          (clk),
    .rst          (reset),
    .clear_i      (load_start),
    .accept_i     (accept),
    .word_i       (load_word),
    .entry_o      (entry),
    .entry_done_o (entry_done)
  );

  always_comb begin
    state_d     = state_q;
    entry_cnt_d = entry_cnt_q;
    load_err_d  = 1'b0;
    if (load_start) begin
      state_d     = ST_LOAD;
      entry_cnt_d = '0;
    end else if (accept) begin
      if (entry_done) entry_cnt_d = entry_cnt_q + IDX_BITS'(1);
      if (load_last && is_final) begin
        state_d = ST_READY;
      end else if (load_last || is_final) begin
        // Framing mismatch: whatever was already written stays, but not ready.
        state_d    = ST_IDLE;
        load_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      entry_cnt_q <= '0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_cnt_q <= entry_cnt_d;
      load_err_q  <= load_err_d;
    end
  end

  // Entry 0 is never written; the read mux substitutes zero for it.
  always_ff @(posedge clk) begin
    if (wr_en) tbl_q[entry_cnt_q + IDX_BITS'(1)] <= entry;
  end

  assign load_ready  = (state_q == ST_LOAD);
  assign table_ready = is_ready;
  assign load_err    = load_err_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [IDX_BITS-1:0]  idx;
    logic [DATA_BITS-1:0] data_q;
    logic                 vld_q, err_q;

    assign idx = rd_idx[p*IDX_BITS +: IDX_BITS];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_q <= '0;
        vld_q  <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        vld_q <= rd_valid[p] && is_ready;
        err_q <= rd_valid[p] && !is_ready;
        if (rd_valid[p]) data_q <= (is_ready && idx != '0) ? tbl_q[idx] : '0;
      end
    end

    assign rd_data[p*DATA_BITS +: DATA_BITS] = data_q;
    assign rd_data_valid[p]                  = vld_q;
    assign rd_err[p]                         = err_q;
  end
endmodule

// File: tb/tb_xpb_lut_loadable.sv
// Scoreboard bench: a small 2-port table for protocol scenarios and a default
// sized table for a full random load and index sweep.
module tb_xpb_lut_loadable;
  localparam int SI = 2, SD = 64, SW = 32, SP = 2;
  localparam int BI = 5, BD = 1024, BW = 32;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic              s_load_start = 0, s_load_valid = 0, s_load_last = 0;
  logic [SW-1:0]     s_load_word = '0;
  logic              s_load_ready, s_load_err, s_table_ready;
  logic [SP-1:0]     s_rd_valid = '0;
  logic [SP*SI-1:0]  s_rd_idx = '0;
  logic [SP*SD-1:0]  s_rd_data;
  logic [SP-1:0]     s_rd_data_valid, s_rd_err;

  logic              b_load_start = 0, b_load_valid = 0, b_load_last = 0;
  logic [BW-1:0]     b_load_word = '0;
  logic              b_load_ready, b_load_err, b_table_ready;
  logic [0:0]        b_rd_valid = '0;
  logic [BI-1:0]     b_rd_idx = '0;
  logic [BD-1:0]     b_rd_data;
  logic [0:0]        b_rd_data_valid, b_rd_err;

  xpb_lut_loadable #(.IDX_BITS(SI), .DATA_BITS(SD), .LOAD_WORD(SW), .NUM_PORTS(SP)) u_small (
    .clk(clk), .reset(reset), .load_start(s_load_start), .load_valid(s_load_valid),
    .load_word(s_load_word), .load_last(s_load_last), .load_ready(s_load_ready),
    .load_err(s_load_err), .table_ready(s_table_ready), .rd_valid(s_rd_valid),
    .rd_idx(s_rd_idx), .rd_data(s_rd_data), .rd_data_valid(s_rd_data_valid), .rd_err(s_rd_err));

  xpb_lut_loadable #(.IDX_BITS(BI), .DATA_BITS(BD), .LOAD_WORD(BW), .NUM_PORTS(1)) u_big (
    .clk(clk), .reset(reset), .load_start(b_load_start), .load_valid(b_load_valid),
    .load_word(b_load_word), .load_last(b_load_last), .load_ready(b_load_ready),
    .load_err(b_load_err), .table_ready(b_table_ready), .rd_valid(b_rd_valid),
    .rd_idx(b_rd_idx), .rd_data(b_rd_data), .rd_data_valid(b_rd_data_valid), .rd_err(b_rd_err));

  typedef struct { int port; logic [SD-1:0] data; logic vld; logic err; } s_exp_t;
  typedef struct { logic [BD-1:0] data; logic vld; logic err; } b_exp_t;

  s_exp_t        sq[$];
  b_exp_t        bq[$];
  logic [SD-1:0] smdl[4];
  logic [SD-1:0] s_last[2];
  bit            s_rdy;
  logic [BD-1:0] bmdl[32];
  int n_chk = 0, n_fail = 0;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Drives one lookup cycle on the small table and queues what each port must show.
  task automatic s_drive_rd(input bit v0, input int i0, input bit v1, input int i1);
    bit v[2];
    int ix[2];
    s_exp_t e;
    v[0] = v0; v[1] = v1; ix[0] = i0; ix[1] = i1;
    s_rd_valid = {v1, v0};
    s_rd_idx   = {2'(i1), 2'(i0)};
    for (int p = 0; p < 2; p++) begin
      e.port = p;
      if (v[p] && s_rdy)  begin e.data = smdl[ix[p]]; e.vld = 1; e.err = 0; end
      else if (v[p])      begin e.data = '0;          e.vld = 0; e.err = 1; end
      else                begin e.data = s_last[p];   e.vld = 0; e.err = 0; end
      s_last[p] = e.data;
      sq.push_back(e);
    end
  endtask

  task automatic s_start;
    s_load_start = 1; tick; s_load_start = 0; s_rdy = 0;
  endtask

  task automatic s_word(input logic [SW-1:0] w, input bit last);
    s_load_valid = 1; s_load_word = w; s_load_last = last;
    tick;
    s_load_valid = 0; s_load_last = 0;
  endtask

  task automatic test_reset;
    repeat (2) tick;
    n_chk++;
    if ({s_load_ready, s_load_err, s_table_ready, s_rd_data_valid, s_rd_err} !== '0 || s_rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_small: got rdy=%b err=%b tr=%b dv=%b re=%b data=%h, expected all zero",
               s_load_ready, s_load_err, s_table_ready, s_rd_data_valid, s_rd_err, s_rd_data);
    end
    n_chk++;
    if ({b_load_ready, b_load_err, b_table_ready, b_rd_data_valid, b_rd_err} !== '0 || b_rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_big: got rdy=%b err=%b tr=%b dv=%b re=%b, expected all zero",
               b_load_ready, b_load_err, b_table_ready, b_rd_data_valid, b_rd_err);
    end
    reset = 0;
    tick;
    n_chk++;
    if (s_table_ready !== 1'b0 || s_load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got tr=%b lr=%b, expected 0 0", s_table_ready, s_load_ready);
    end
  endtask

  task automatic test_good_load;
    s_start;
    n_chk++;
    if (s_load_ready !== 1'b1) begin
      n_fail++; $display("FAIL load_ready: got %b expected 1", s_load_ready);
    end
    for (int w = 1; w <= 6; w++) begin
      s_word(SW'(w), w == 6);
      if (w == 5) begin
        n_chk++;
        if (s_table_ready !== 1'b0) begin
          n_fail++; $display("FAIL ready_early: got %b expected 0", s_table_ready);
        end
      end
    end
    n_chk++;
    if (s_table_ready !== 1'b1 || s_load_ready !== 1'b0 || s_load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL good_load_done: got tr=%b lr=%b err=%b expected 1 0 0", s_table_ready, s_load_ready, s_load_err);
    end
    smdl[1] = 64'h0000000200000001;
    smdl[2] = 64'h0000000400000003;
    smdl[3] = 64'h0000000600000005;
    s_rdy = 1;
    for (int c = 0; c < 3; c++) begin
      if (c == 0)      s_drive_rd(1, 1, 1, 2);
      else if (c == 1) s_drive_rd(1, 3, 0, 0);
      else             s_drive_rd(0, 0, 0, 0);
      tick;
      while (sq.size() > 0) begin
        s_exp_t e = sq.pop_front();
        n_chk++;
        if (s_rd_data[e.port*SD +: SD] !== e.data || s_rd_data_valid[e.port] !== e.vld || s_rd_err[e.port] !== e.err) begin
          n_fail++;
          $display("FAIL readback_p%0d: got data=%h vld=%b err=%b expected data=%h vld=%b err=%b", e.port,
                   s_rd_data[e.port*SD +: SD], s_rd_data_valid[e.port], s_rd_err[e.port], e.data, e.vld, e.err);
        end
      end
    end
  endtask

  task automatic test_dual_port;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) s_drive_rd(1, 0, 1, 3);
      else        s_drive_rd(0, 0, 0, 0);
      tick;
      while (sq.size() > 0) begin
        s_exp_t e = sq.pop_front();
        n_chk++;
        if (s_rd_data[e.port*SD +: SD] !== e.data || s_rd_data_valid[e.port] !== e.vld || s_rd_err[e.port] !== e.err) begin
          n_fail++;
          $display("FAIL dual_port_p%0d: got data=%h vld=%b err=%b expected data=%h vld=%b err=%b", e.port,
                   s_rd_data[e.port*SD +: SD], s_rd_data_valid[e.port], s_rd_err[e.port], e.data, e.vld, e.err);
        end
      end
    end
  endtask

  task automatic test_early_last;
    s_start;
    for (int w = 1; w <= 4; w++) s_word(SW'(32'h40 + w), w == 4);
    n_chk++;
    if (s_load_err !== 1'b1 || s_table_ready !== 1'b0 || s_load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL early_last: got err=%b tr=%b lr=%b expected 1 0 0", s_load_err, s_table_ready, s_load_ready);
    end
    tick;
    n_chk++;
    if (s_load_err !== 1'b0) begin
      n_fail++; $display("FAIL early_last_pulse: got %b expected 0", s_load_err);
    end
    s_drive_rd(1, 1, 1, 2);
    tick;
    s_rd_valid = '0;
    while (sq.size() > 0) begin
      s_exp_t e = sq.pop_front();
      n_chk++;
      if (s_rd_data[e.port*SD +: SD] !== e.data || s_rd_data_valid[e.port] !== e.vld || s_rd_err[e.port] !== e.err) begin
        n_fail++;
        $display("FAIL not_ready_rd_p%0d: got data=%h vld=%b err=%b expected data=%h vld=%b err=%b", e.port,
                 s_rd_data[e.port*SD +: SD], s_rd_data_valid[e.port], s_rd_err[e.port], e.data, e.vld, e.err);
      end
    end
  endtask

  task automatic test_missing_last;
    s_start;
    for (int w = 1; w <= 6; w++) begin
      s_word(SW'(32'h80 + w), 1'b0);
      if (w == 5) begin
        n_chk++;
        if (s_load_err !== 1'b0 || s_load_ready !== 1'b1) begin
          n_fail++; $display("FAIL missing_last_w5: got err=%b lr=%b expected 0 1", s_load_err, s_load_ready);
        end
      end
    end
    n_chk++;
    if (s_load_err !== 1'b1 || s_load_ready !== 1'b0 || s_table_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL missing_last: got err=%b lr=%b tr=%b expected 1 0 0", s_load_err, s_load_ready, s_table_ready);
    end
    tick;
    n_chk++;
    if (s_load_err !== 1'b0 || s_load_ready !== 1'b0) begin
      n_fail++; $display("FAIL missing_last_idle: got err=%b lr=%b expected 0 0", s_load_err, s_load_ready);
    end
  endtask

  task automatic test_reload_reset;
    s_start;
    for (int w = 1; w <= 6; w++) s_word(SW'(32'h10 + w), w == 6);
    smdl[1] = 64'h0000001200000011;
    smdl[2] = 64'h0000001400000013;
    smdl[3] = 64'h0000001600000015;
    s_rdy = 1;
    n_chk++;
    if (s_table_ready !== 1'b1) begin
      n_fail++; $display("FAIL reload_ready: got %b expected 1", s_table_ready);
    end
    // Lookup captured in the same cycle as load_start still sees READY.
    s_drive_rd(1, 1, 0, 0);
    s_load_start = 1;
    tick;
    s_load_start = 0; s_rdy = 0; s_rd_valid = '0;
    while (sq.size() > 0) begin
      s_exp_t e = sq.pop_front();
      n_chk++;
      if (s_rd_data[e.port*SD +: SD] !== e.data || s_rd_data_valid[e.port] !== e.vld || s_rd_err[e.port] !== e.err) begin
        n_fail++;
        $display("FAIL start_lookup_p%0d: got data=%h vld=%b err=%b expected data=%h vld=%b err=%b", e.port,
                 s_rd_data[e.port*SD +: SD], s_rd_data_valid[e.port], s_rd_err[e.port], e.data, e.vld, e.err);
      end
    end
    n_chk++;
    if (s_table_ready !== 1'b0 || s_load_ready !== 1'b1) begin
      n_fail++; $display("FAIL reload_state: got tr=%b lr=%b expected 0 1", s_table_ready, s_load_ready);
    end
    for (int w = 1; w <= 3; w++) s_word(SW'(32'h20 + w), 1'b0);
    reset = 1;
    #1;
    n_chk++;
    if ({s_load_ready, s_load_err, s_table_ready, s_rd_data_valid, s_rd_err} !== '0 || s_rd_data !== '0) begin
      n_fail++;
      $display("FAIL mid_load_reset: got lr=%b err=%b tr=%b dv=%b re=%b data=%h expected all zero",
               s_load_ready, s_load_err, s_table_ready, s_rd_data_valid, s_rd_err, s_rd_data);
    end
    s_last[0] = '0; s_last[1] = '0;
    tick;
    reset = 0;
    tick;
    n_chk++;
    if (s_load_err !== 1'b0 || s_load_ready !== 1'b0 || s_table_ready !== 1'b0) begin
      n_fail++; $display("FAIL after_reset: got err=%b lr=%b tr=%b expected 0 0 0", s_load_err, s_load_ready, s_table_ready);
    end
  endtask

  task automatic test_default_config;
    b_exp_t e;
    b_load_start = 1; tick; b_load_start = 0;
    bmdl[0] = '0;
    for (int en = 1; en < 32; en++)
      for (int w = 0; w < 32; w++) begin
        b_load_word = $urandom;
        bmdl[en][w*BW +: BW] = b_load_word;
        b_load_valid = 1;
        b_load_last = (en == 31 && w == 31);
        tick;
      end
    b_load_valid = 0; b_load_last = 0;
    n_chk++;
    if (b_table_ready !== 1'b1 || b_load_err !== 1'b0 || b_load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL big_load: got tr=%b err=%b lr=%b expected 1 0 0", b_table_ready, b_load_err, b_load_ready);
    end
    for (int i = 0; i < 32; i++) begin
      b_rd_valid = 1'b1;
      b_rd_idx = BI'(i);
      e.data = bmdl[i]; e.vld = 1; e.err = 0;
      bq.push_back(e);
      tick;
      e = bq.pop_front();
      n_chk++;
      if (b_rd_data !== e.data || b_rd_data_valid !== e.vld || b_rd_err !== e.err) begin
        n_fail++;
        $display("FAIL sweep_idx%0d: got vld=%b err=%b data[63:0]=%h expected vld=%b err=%b data[63:0]=%h",
                 i, b_rd_data_valid, b_rd_err, b_rd_data[63:0], e.vld, e.err, e.data[63:0]);
      end
    end
    b_rd_valid = 1'b0;
    tick;
    n_chk++;
    if (b_rd_data_valid !== 1'b0 || b_rd_data !== bmdl[31]) begin
      n_fail++;
      $display("FAIL big_hold: got vld=%b data[63:0]=%h expected 0 %h", b_rd_data_valid, b_rd_data[63:0], bmdl[31][63:0]);
    end
  endtask

  initial begin
    smdl[0] = '0; smdl[1] = '0; smdl[2] = '0; smdl[3] = '0;
    s_last[0] = '0; s_last[1] = '0;
    s_rdy = 0;
    test_reset;
    test_good_load;
    test_dual_port;
    test_early_last;
    test_missing_last;
    test_reload_reset;
    test_default_config;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/xpb_lut_loadable.md
# xpb_lut_loadable

Run-time loadable, multi-port successor to the fixed XPB reduction tables used by the modular squarer. It stores `2**IDX_BITS` precomputed reduction constants of `DATA_BITS` each; entry 0 is hardwired zero. Entries 1..N-1 are streamed in as narrow words, so one netlist can serve any modulus without resynthesis. `NUM_PORTS` independent lookup channels read the table with a registered one-cycle latency. It sits between the host/config loader and the reduction adder tree.

## Interface
- IDX_BITS, 5, lookup index width; `ENTRIES = 2**IDX_BITS`
- DATA_BITS, 1024, width of each table entry
- LOAD_WORD, 32, load bus width; must divide DATA_BITS; `WPE = DATA_BITS/LOAD_WORD`
- NUM_PORTS, 1, number of independent lookup channels

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- load_start  in  1  pulse; clears the table-ready state and begins a new load
- load_valid  in  1  load word present
- load_word  in  LOAD_WORD  load data, least-significant word of each entry first
- load_last  in  1  marks the final word of the whole load
- load_ready  out  1  high in LOAD
- load_err  out  1  one-cycle pulse on a malformed load
- table_ready  out  1  high in READY
- rd_valid  in  NUM_PORTS  per-channel lookup request
- rd_idx  in  NUM_PORTS*IDX_BITS  per-channel index, channel p at `[p*IDX_BITS +: IDX_BITS]`
- rd_data  out  NUM_PORTS*DATA_BITS  per-channel result
- rd_data_valid  out  NUM_PORTS  per-channel result valid
- rd_err  out  NUM_PORTS  pulse: lookup requested while not READY

## Operation
- FSM states: IDLE, LOAD, READY. Reset enters IDLE.
- **load_start** in any state:
  - next state is LOAD;
  - word counter and entry counter clear to 0 (entry pointer targets entry 1);
  - table contents are not cleared;
  - load_start has priority over load_valid in the same cycle.
- **LOAD:**
  - Each cycle with load_valid, one word is accepted into an entry accumulator at word position `word_cnt`.
  - When `word_cnt == WPE-1`, the assembled entry is written to `table[entry_cnt+1]`, word_cnt wraps to 0, and entry_cnt increments.
  - Total words expected: `(ENTRIES-1)*WPE`.
  - load_last together with the final expected word: last entry written, state goes to READY.
  - load_last on any other word: load_err pulses, state goes to IDLE. Entries already written remain, but table_ready stays 0.
  - Final expected word without load_last: load_err pulses, state goes to IDLE.
- **READY:** holds until load_start or reset. load_valid is ignored outside LOAD.
- **Lookup, per channel p, independently:**
  - In READY, with rd_valid[p]: the next cycle gives `rd_data[p] = table[rd_idx[p]]`, with `rd_data[p] = 0` when idx = 0, and `rd_data_valid[p] = 1`.
  - Not in READY, with rd_valid[p]: the next cycle gives rd_err[p] = 1, rd_data_valid[p] = 0, rd_data[p] = 0.
  - rd_data holds its last value when rd_valid[p] = 0. rd_data_valid and rd_err are single-cycle per request.
- Readiness is sampled in the request cycle. A lookup issued in the same cycle as load_start, while in READY, still succeeds with the old contents.

## Timing
- Reset values:
  - state = IDLE, counters 0;
  - load_ready = 0, load_err = 0, table_ready = 0;
  - rd_data = 0, rd_data_valid = 0, rd_err = 0.
  - Table registers are not reset.
- Lookup latency is 1 cycle, fully pipelined: one request per channel per cycle.
- Load throughput is one word per cycle. The final word is accepted in cycle t and table_ready = 1 in cycle t+1.
- load_err is asserted in the cycle after the offending word.
- Reset mid-load aborts immediately to IDLE, with no error pulse.

## Structure
- Shared package `xpb_pkg` holds:
  - the FSM state enum `xpb_state_t`;
  - default constants `XPB_IDX_BITS = 5`, `XPB_DATA_BITS = 1024`, `XPB_LOAD_WORD = 32`.
- Sub-module `xpb_entry_accum` handles word-to-entry assembly: word counter, shift/insert accumulator, `entry_done` strobe.
- The top level holds the FSM, entry counter, register table and per-channel read registers (generate loop over NUM_PORTS).

## Test plan
Use `IDX_BITS=2, DATA_BITS=64, LOAD_WORD=32, NUM_PORTS=2` unless stated.

- **Good load:**
  - Stimulus: load_start, then 6 words 0x1,0x2,0x3,0x4,0x5,0x6, with load_last on the 6th.
  - Expected: table_ready rises one cycle after the 6th word.
  - Expected contents: table[1] = 0x0000000200000001, table[2] = 0x0000000400000003, table[3] = 0x0000000600000005.
- **Dual-port lookup:**
  - Stimulus: after the good load, rd_idx = {3,0}, both valid.
  - Expected: the next cycle gives rd_data = {0x0000000600000005, 0}, both rd_data_valid = 1.
- **Early load_last:**
  - Stimulus: load_last on the 4th word.
  - Expected: load_err pulses once, state returns to IDLE, table_ready = 0.
  - Follow-up: a lookup now gives rd_err = 1 and rd_data_valid = 0.
- **Missing load_last:**
  - Stimulus: 6 words without load_last.
  - Expected: load_err after the 6th word, then IDLE.
- **Reload and reset:**
  - Stimulus: in READY, load_start with a simultaneous lookup of idx 1.
  - Expected: the lookup returns the old value, then table_ready = 0.
  - Stimulus: assert reset after 3 words.
  - Expected: IDLE, no load_err, all outputs at reset values.
- **Default configuration:**
  - Stimulus: load 31×32 words with a random entry pattern, then sweep all 32 indices back-to-back.
  - Expected: every result matches the model at 1-cycle latency; idx 0 returns 0.
